// File: rtl/bin_acc_pkg.sv
// Shared constants, header field layout and FSM encoding for the binary max-pool engine.
package bin_acc_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Header word that explicitly ends a stream; also written after the last record.
    localparam logic [15:0] TERM_WORD = 16'h00FF;

    // Position of the row count N inside a header word.
    localparam int N_LSB = 0;
    localparam int N_MSB = 4;
    localparam int N_W   = N_MSB - N_LSB + 1;

    // Each state names the kind of word present on the read-data bus in that cycle.
    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_HDR  = 5'b00010,
        S_ROWA = 5'b00100,
        S_ROWB = 5'b01000,
        S_TERM = 5'b10000
    } state_t;

endpackage

// File: rtl/bin_pool_row.sv
// 2x2 stride-2 binary max of two rows; pooled bits at index half and above are zero.
module bin_pool_row
    import bin_acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] row_a,
    input  logic [DATA_W-1:0] row_b,
    input  logic [N_W-1:0]    half,
    output logic [DATA_W-1:0] pooled
);

    // OR each 2x2 window; only the first half columns of the pooled word carry data.
    always_comb begin
        // NOTE: assigning a default before any conditional write keeps this block free of latches.
        pooled = '0;
        for (int j = 0; j < DATA_W / 2; j++) begin
            if (j < int'(half)) begin
                pooled[j] = row_a[2*j] | row_a[2*j+1] | row_b[2*j] | row_b[2*j+1];
            end
        end
    end

endmodule

// File: rtl/bin_maxpool.sv
// Streams header/row records from the conv SRAM, pools row pairs and writes the
// pooled records plus a terminator word into the result SRAM.
module bin_maxpool
    import bin_acc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              dut_run,
    output logic              dut_busy,
    output logic [ADDR_W-1:0] pool_sram_read_address,
    input  logic [DATA_W-1:0] sram_pool_read_data,
    output logic [ADDR_W-1:0] pool_sram_write_address,
    output logic [DATA_W-1:0] pool_sram_write_data,
    output logic              pool_sram_write_enable
);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] row_a;
    logic [N_W-1:0]    half;
    logic [N_W-1:0]    pair_cnt;
    logic [N_W-1:0]    n_field;
    logic              hdr_term;
    logic              pair_last;
    logic [DATA_W-1:0] pooled;
    logic              wr_en_nxt;
    logic [DATA_W-1:0] wr_data_nxt;

    // The address is issued from IDLE onward, so the word on the bus in HDR is already the header.
    assign n_field   = sram_pool_read_data[N_MSB:N_LSB];
    assign hdr_term  = (sram_pool_read_data == DATA_W'(TERM_WORD)) || n_field[0] ||
                       (n_field < N_W'(2)) || (32'(n_field) > 32'(DATA_W));
    assign pair_last = (pair_cnt == half - 1'b1);

    bin_pool_row #(
        .DATA_W (DATA_W)
    ) u_pool (
        .row_a  (row_a),
        .row_b  (sram_pool_read_data),
        .half   (half),
        .pooled (pooled)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Next-state decode; a run request is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (dut_run) state_nxt = S_HDR;
            S_HDR:   state_nxt = hdr_term ? S_TERM : S_ROWA;
            S_ROWA:  state_nxt = S_ROWB;
            S_ROWB:  state_nxt = pair_last ? S_HDR : S_ROWA;
            S_TERM:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next write strobe/data: header (or terminator) from HDR, pooled word from ROWB.
    always_comb begin
        wr_en_nxt   = 1'b0;
        wr_data_nxt = pool_sram_write_data;
        unique case (state)
            S_HDR: begin
                wr_en_nxt   = 1'b1;
                wr_data_nxt = hdr_term ? DATA_W'(TERM_WORD) : DATA_W'(n_field >> 1);
            end
            S_ROWB: begin
                wr_en_nxt   = 1'b1;
                wr_data_nxt = pooled;
            end
            default: ;
        endcase
    end

    // Output registers, address counters, row buffer and pair counter.
    always_ff @(posedge clk) begin
        if (reset_b) begin
            dut_busy                <= 1'b0;
            pool_sram_read_address  <= '0;
            pool_sram_write_address <= '0;
            pool_sram_write_data    <= '0;
            pool_sram_write_enable  <= 1'b0;
            row_a                   <= '0;
            half                    <= '0;
            pair_cnt                <= '0;
        end else begin
            dut_busy               <= (state_nxt != S_IDLE);
            pool_sram_write_enable <= wr_en_nxt;
            pool_sram_write_data   <= wr_data_nxt;

            // Both addresses park at 0 whenever the engine is (or is about to be) idle.
            if (state_nxt == S_IDLE) begin
                pool_sram_read_address  <= '0;
                pool_sram_write_address <= '0;
            end else begin
                pool_sram_read_address <= pool_sram_read_address + 1'b1;
                if (pool_sram_write_enable) begin
                    pool_sram_write_address <= pool_sram_write_address + 1'b1;
                end
            end

            if (state == S_HDR && !hdr_term) begin
                half     <= n_field >> 1;
                pair_cnt <= '0;
            end
            if (state == S_ROWA) begin
                row_a <= sram_pool_read_data;
            end
            if (state == S_ROWB) begin
                pair_cnt <= pair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bin_maxpool.sv
// Self-checking bench for bin_maxpool: directed record streams plus randomized
// streams, compared against a record-level reference model.
module tb_bin_maxpool;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset_b = 1'b1;
    logic              dut_run = 1'b0;
    logic              dut_busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;

    bin_maxpool #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk                     (clk),
        .reset_b                 (reset_b),
        .dut_run                 (dut_run),
        .dut_busy                (dut_busy),
        .pool_sram_read_address  (rd_addr),
        .sram_pool_read_data     (rd_data),
        .pool_sram_write_address (wr_addr),
        .pool_sram_write_data    (wr_data),
        .pool_sram_write_enable  (wr_en)
    );

    always #5 clk = ~clk;

    // Conv-result SRAM: one-cycle registered read.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write/busy monitor sampled mid-cycle.
    logic [ADDR_W-1:0] cap_addr [$];
    logic [DATA_W-1:0] cap_data [$];
    int busy_cnt = 0;
    int rd_err   = 0;

    always @(negedge clk) begin
        if (wr_en) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
        end
        if (dut_busy) begin
            // While busy the read address runs one ahead of the busy-cycle index.
            if (rd_addr != ADDR_W'(busy_cnt + 1)) rd_err++;
            busy_cnt++;
        end
    end

    logic [15:0] stim [$];
    logic [15:0] exp_q [$];
    int          exp_busy;

    task automatic load_stim();
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < stim.size(); i++) mem[i] = stim[i];
    endtask

    // Reference: walk records, pool each 2x2 window, append the terminator.
    task automatic model();
        int pos;
        int n;
        logic [15:0] h;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] o;
        exp_q.delete();
        pos = 0;
        forever begin
            h = mem[pos];
            pos++;
            n = int'(h & 16'h1F);
            if (h == 16'h00FF || (n % 2) != 0 || n < 2 || n > DATA_W) break;
            exp_q.push_back(16'(n / 2));
            for (int k = 0; k < n / 2; k++) begin
                a = mem[pos];
                b = mem[pos + 1];
                pos += 2;
                o = '0;
                for (int j = 0; j < n / 2; j++) begin
                    if ((((a | b) >> (2 * j)) & 16'h3) != 0) o[j] = 1'b1;
                end
                exp_q.push_back(o);
            end
        end
        exp_q.push_back(16'h00FF);
        // Busy covers one cycle per consumed word plus the terminator write cycle.
        exp_busy = pos + 1;
    endtask

    task automatic do_reset();
        reset_b = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b0;
    endtask

    // Run the loaded stream and compare every write against the model.
    task automatic run_case(input string tag, input bit spam);
        int cycles;
        model();
        cap_addr.delete();
        cap_data.delete();
        busy_cnt = 0;
        rd_err   = 0;
        @(negedge clk);
        dut_run = 1'b1;
        @(negedge clk);
        dut_run = 1'b0;
        cycles = 0;
        while (dut_busy && cycles < 3000) begin
            @(negedge clk);
            cycles++;
            if (spam && dut_busy) dut_run = 1'($urandom_range(0, 1));
        end
        dut_run = 1'b0;
        if (cycles >= 3000) begin
            check({tag, "_timeout"}, 1, 0);
            do_reset();
        end
        check({tag, "_nwrites"}, cap_data.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), cap_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), cap_data[i], exp_q[i]);
        end
        check({tag, "_busy"}, busy_cnt, exp_busy);
        check({tag, "_rdseq"}, rd_err, 0);
        check({tag, "_raddr_idle"}, rd_addr, 0);
        check({tag, "_waddr_idle"}, wr_addr, 0);
    endtask

    task automatic gen_random();
        int nrec;
        int n;
        stim.delete();
        nrec = $urandom_range(1, 3);
        for (int r = 0; r < nrec; r++) begin
            n = 2 * $urandom_range(1, 8);
            stim.push_back(16'(n));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) != 0) stim.push_back(16'($urandom & $urandom & $urandom));
                else                           stim.push_back(16'($urandom));
            end
        end
        case ($urandom_range(0, 3))
            0:       stim.push_back(16'h00FF);
            1:       stim.push_back(16'(2 * $urandom_range(0, 15) + 1));
            2:       stim.push_back(16'h0000);
            default: stim.push_back(16'(2 * $urandom_range(9, 15)));
        endcase
    endtask

    logic [15:0] lit030 [6] = '{16'h0004, 16'h0001, 16'h0008, 16'h0004, 16'h0002, 16'h00FF};
    int          cycles_left;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        do_reset();
        #1;
        check("rst_busy", dut_busy, 0);
        check("rst_we", wr_en, 0);
        check("rst_raddr", rd_addr, 0);
        check("rst_waddr", wr_addr, 0);
        check("rst_wdata", wr_data, 0);

        // N=8 sparse rows.
        stim = '{16'd8, 16'h01, 16'h00, 16'h80, 16'h00, 16'h00, 16'h10, 16'h00, 16'h04, 16'h00FF};
        load_stim();
        run_case("n8", 1'b0);
        for (int i = 0; i < 6 && i < cap_data.size(); i++)
            check($sformatf("n8_lit%0d", i), cap_data[i], lit030[i]);

        // N=14 all ones.
        stim.delete();
        stim.push_back(16'd14);
        for (int i = 0; i < 14; i++) stim.push_back(16'h3FFF);
        stim.push_back(16'h00FF);
        load_stim();
        run_case("n14", 1'b0);
        check("n14_busy17", busy_cnt, 17);

        // Two records back to back.
        stim.delete();
        stim.push_back(16'd10);
        for (int i = 0; i < 10; i++) stim.push_back(16'($urandom));
        stim.push_back(16'd8);
        for (int i = 0; i < 8; i++) stim.push_back(16'($urandom));
        stim.push_back(16'h00FF);
        load_stim();
        run_case("n10n8", 1'b0);
        check("n10n8_count", cap_data.size(), 12);

        // Odd first header terminates immediately.
        stim = '{16'h0007};
        load_stim();
        run_case("odd", 1'b0);

        // Reset during ROWB of the second pair of an N=8 record.
        stim = '{16'd8, 16'h01, 16'h00, 16'h80, 16'h00, 16'h00, 16'h10, 16'h00, 16'h04, 16'h00FF};
        load_stim();
        cap_addr.delete();
        cap_data.delete();
        @(negedge clk);
        dut_run = 1'b1;
        @(posedge clk);
        #1 dut_run = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset_b = 1'b1;
        @(posedge clk);
        #1;
        check("abort_we", wr_en, 0);
        check("abort_busy", dut_busy, 0);
        check("abort_raddr", rd_addr, 0);
        check("abort_waddr", wr_addr, 0);
        check("abort_wdata", wr_data, 0);
        @(negedge clk);
        reset_b = 1'b0;
        check("abort_nwrites", cap_data.size(), 2);
        run_case("rerun", 1'b0);

        // Randomized streams, some with run pulses spammed while busy.
        for (int t = 0; t < 8; t++) begin
            gen_random();
            load_stim();
            run_case($sformatf("rnd%0d", t), t >= 5);
        end

        // No spurious activity once idle.
        cycles_left = 0;
        repeat (5) begin
            @(negedge clk);
            if (dut_busy || wr_en) cycles_left++;
        end
        check("idle_quiet", cycles_left, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
